// File: rtl/gcm_result_viewer.sv
// gcm_result_viewer: captures AES-GCM ciphertext/tag pairs into a small history
// ring on each rising tag_ready, and presents a registered hex window of a
// selected entry to the seven-segment display driver, with optional auto-scroll.
module gcm_result_viewer #(
    parameter int DATA_W     = 128,
    parameter int DIGITS     = 4,
    parameter int DEPTH      = 4,
    parameter int SCROLL_DIV = 50_000_000,
    localparam int WIN_W     = 4 * DIGITS,
    localparam int NWIN      = DATA_W / WIN_W,
    localparam int WB        = $clog2(NWIN),
    localparam int EB        = $clog2(DEPTH),
    localparam int PW        = $clog2(SCROLL_DIV)
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [0:DATA_W-1] i_cipher_text,
    input  logic [0:DATA_W-1] i_tag,
    input  logic              i_tag_ready,
    input  logic              i_clear,
    input  logic              i_sel_tag,
    input  logic [EB-1:0]     i_entry,
    input  logic [WB-1:0]     i_window,
    input  logic              i_scroll_en,
    output logic [WIN_W-1:0]  o_digits,
    output logic              o_valid,
    output logic [EB:0]       o_count,
    output logic [WB-1:0]     o_window,
    output logic              o_capture_pulse
);

    typedef enum logic {
        MANUAL = 1'b0,
        SCROLL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [WB-1:0]     window_q, window_d;
    logic              tr_q, tr_d;
    logic [EB-1:0]     wp_q, wp_d;
    logic [EB:0]       count_q, count_d;
    logic [WIN_W-1:0]  digits_q, digits_d;
    logic              valid_q, valid_d;
    logic              pulse_q, pulse_d;

    logic              capture;
    logic [EB-1:0]     wp_base;
    logic [EB:0]       count_base;
    logic [EB-1:0]     wr_slot;
    logic [EB-1:0]     rd_slot;
    logic [0:DATA_W-1] sel_word;

    logic [0:DATA_W-1] cipher_mem [DEPTH];
    logic [0:DATA_W-1] tag_mem    [DEPTH];

    // Capture path: rising-edge detect, clear applied before any same-cycle capture
    always_comb begin
        capture    = i_tag_ready & ~tr_q;
        tr_d       = i_tag_ready;
        pulse_d    = capture;
        wp_base    = i_clear ? '0 : wp_q;
        count_base = i_clear ? '0 : count_q;
        wr_slot    = wp_base;
        wp_d       = wp_base;
        count_d    = count_base;
        if (capture) begin
            wp_d = wp_base + EB'(1);
            if (count_base != (EB+1)'(DEPTH)) begin
                count_d = count_base + (EB+1)'(1);
            end
        end
    end

    // Scroll state machine: manual window follows input, scroll steps on prescaler wrap
    always_comb begin
        state_d  = i_scroll_en ? SCROLL : MANUAL;
        presc_d  = '0;
        window_d = i_window;
        unique case (state_q)
            MANUAL: begin
                if (i_scroll_en) begin
                    window_d = '0;
                end
            end
            SCROLL: begin
                if (i_scroll_en) begin
                    window_d = window_q;
                    if (presc_q == PW'(SCROLL_DIV - 1)) begin
                        window_d = window_q + WB'(1);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            default: begin
                window_d = i_window;
            end
        endcase
    end

    // Output window select from stored data, using the next window so digits track o_window
    always_comb begin
        rd_slot  = wp_q - EB'(1) - i_entry;
        valid_d  = ({1'b0, i_entry} < count_q);
        sel_word = i_sel_tag ? tag_mem[rd_slot] : cipher_mem[rd_slot];
        digits_d = '0;
        if (valid_d) begin
            for (int w = 0; w < NWIN; w++) begin
                if (window_d == WB'(w)) begin
                    digits_d = sel_word[w*WIN_W +: WIN_W];
                end
            end
        end
    end

    // History storage: contents need no reset, validity comes from the count
    always_ff @(posedge clk) begin
        if (capture) begin
            cipher_mem[wr_slot] <= i_cipher_text;
            tag_mem[wr_slot]    <= i_tag;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= MANUAL;
            presc_q  <= '0;
            window_q <= '0;
            tr_q     <= 1'b0;
            wp_q     <= '0;
            count_q  <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            window_q <= window_d;
            tr_q     <= tr_d;
            wp_q     <= wp_d;
            count_q  <= count_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            pulse_q  <= pulse_d;
        end
    end

    assign o_digits        = digits_q;
    assign o_valid         = valid_q;
    assign o_count         = count_q;
    assign o_window        = window_q;
    assign o_capture_pulse = pulse_q;

endmodule

// File: tb/tb_gcm_result_viewer.sv
// Testbench for gcm_result_viewer: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue-based model.
module tb_gcm_result_viewer;

    logic         clk;
    logic         i_reset;
    logic [127:0] i_cipher_text;
    logic [127:0] i_tag;
    logic         i_tag_ready;
    logic         i_clear;
    logic         i_sel_tag;
    logic [1:0]   i_entry;
    logic [2:0]   i_window;
    logic         i_scroll_en;
    logic [15:0]  o_digits;
    logic         o_valid;
    logic [2:0]   o_count;
    logic [2:0]   o_window;
    logic         o_capture_pulse;

    int checks = 0;
    int errors = 0;

    gcm_result_viewer #(
        .DATA_W(128), .DIGITS(4), .DEPTH(4), .SCROLL_DIV(8)
    ) dut (
        .clk(clk), .i_reset(i_reset),
        .i_cipher_text(i_cipher_text), .i_tag(i_tag),
        .i_tag_ready(i_tag_ready), .i_clear(i_clear),
        .i_sel_tag(i_sel_tag), .i_entry(i_entry),
        .i_window(i_window), .i_scroll_en(i_scroll_en),
        .o_digits(o_digits), .o_valid(o_valid), .o_count(o_count),
        .o_window(o_window), .o_capture_pulse(o_capture_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: newest-first history queues, scroll position from elapsed cycles
    logic [127:0] hist_c[$];
    logic [127:0] hist_t[$];
    bit           prev_tr;
    bit           scroll_on;
    int           scroll_cycles;
    logic [15:0]  exp_digits;
    bit           exp_valid;
    bit           exp_pulse;
    int           exp_count;
    int           exp_window;

    function automatic logic [15:0] slice16(logic [127:0] v, int w);
        return v[127 - 16*w -: 16];
    endfunction

    always @(posedge clk or posedge i_reset) begin
        int           nw;
        bit           cap;
        logic [127:0] word;
        if (i_reset) begin
            hist_c.delete();
            hist_t.delete();
            prev_tr       = 0;
            scroll_on     = 0;
            scroll_cycles = 0;
            exp_digits    = '0;
            exp_valid     = 0;
            exp_pulse     = 0;
            exp_count     = 0;
            exp_window    = 0;
        end else begin
            if (!i_scroll_en) begin
                nw = int'(i_window);
            end else if (!scroll_on) begin
                scroll_cycles = 0;
                nw = 0;
            end else begin
                scroll_cycles++;
                nw = (scroll_cycles / 8) % 8;
            end
            scroll_on  = i_scroll_en;
            exp_window = nw;
            exp_valid  = int'(i_entry) < hist_c.size();
            exp_digits = '0;
            if (exp_valid) begin
                word = i_sel_tag ? hist_t[i_entry] : hist_c[i_entry];
                exp_digits = slice16(word, nw);
            end
            cap     = i_tag_ready && !prev_tr;
            prev_tr = i_tag_ready;
            if (i_clear) begin
                hist_c.delete();
                hist_t.delete();
            end
            if (cap) begin
                hist_c.push_front(i_cipher_text);
                hist_t.push_front(i_tag);
                if (hist_c.size() > 4) begin
                    void'(hist_c.pop_back());
                    void'(hist_t.pop_back());
                end
            end
            exp_pulse = cap;
            exp_count = hist_c.size();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        checkOutput("m_pulse",  32'(o_capture_pulse), 32'(exp_pulse));
        checkOutput("m_count",  32'(o_count),         32'(exp_count));
        checkOutput("m_valid",  32'(o_valid),         32'(exp_valid));
        checkOutput("m_window", 32'(o_window),        32'(exp_window));
        checkOutput("m_digits", 32'(o_digits),        32'(exp_digits));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] c, input logic [127:0] t);
        i_cipher_text = c;
        i_tag         = t;
        i_tag_ready   = 1'b1;
        tick();
        i_tag_ready   = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        i_reset       = 1'b1;
        i_cipher_text = '0;
        i_tag         = '0;
        i_tag_ready   = 1'b0;
        i_clear       = 1'b0;
        i_sel_tag     = 1'b0;
        i_entry       = '0;
        i_window      = '0;
        i_scroll_en   = 1'b0;
        repeat (3) tick();
        checkOutput("rst_digits", 32'(o_digits), 32'h0);
        checkOutput("rst_count",  32'(o_count),  32'h0);
        i_reset = 1'b0;
        tick();

        // Scenario 1: single capture with held-high tag_ready
        i_cipher_text = {2{64'h0123_4567_89AB_CDEF}};
        i_tag         = {2{64'hFEDC_BA98_7654_3210}};
        tick();
        i_tag_ready = 1'b1;
        tick();
        checkOutput("s1_pulse_hi", 32'(o_capture_pulse), 32'h1);
        checkOutput("s1_count",    32'(o_count),         32'h1);
        tick();
        checkOutput("s1_pulse_lo", 32'(o_capture_pulse), 32'h0);
        checkOutput("s1_cipher",   32'(o_digits),        32'h0123);
        checkOutput("s1_valid",    32'(o_valid),         32'h1);
        pulses = 0;
        repeat (18) begin
            tick();
            pulses += int'(o_capture_pulse);
        end
        checkOutput("s1_no_recapture", 32'(pulses), 32'h0);
        i_sel_tag = 1'b1;
        tick();
        checkOutput("s1_tag", 32'(o_digits), 32'hFEDC);
        i_sel_tag   = 1'b0;
        i_tag_ready = 1'b0;
        tick();

        // Scenario 2: ring wrap after six captures
        for (int k = 1; k <= 6; k++) applyStimulus(128'(k), 128'(k + 100));
        i_window = 3'd7;
        i_entry  = 2'd0;
        tick();
        checkOutput("s2_count",  32'(o_count),  32'h4);
        checkOutput("s2_entry0", 32'(o_digits), 32'h0006);
        i_entry = 2'd3;
        tick();
        checkOutput("s2_entry3", 32'(o_digits), 32'h0003);

        // Scenario 3: entry beyond the stored count is invalid
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        applyStimulus(128'h11, 128'h0);
        applyStimulus(128'h22, 128'h0);
        tick();
        checkOutput("s3_valid0",  32'(o_valid),  32'h0);
        checkOutput("s3_digits0", 32'(o_digits), 32'h0);
        i_entry = 2'd1;
        tick();
        checkOutput("s3_valid1",  32'(o_valid),  32'h1);
        checkOutput("s3_digits1", 32'(o_digits), 32'h0011);

        // Scenario 4: clear and capture in the same cycle
        applyStimulus(128'h33, 128'h0);
        applyStimulus(128'h44, 128'h0);
        checkOutput("s4_full", 32'(o_count), 32'h4);
        i_entry       = 2'd0;
        i_cipher_text = 128'hAAAA;
        i_clear       = 1'b1;
        i_tag_ready   = 1'b1;
        tick();
        i_clear     = 1'b0;
        i_tag_ready = 1'b0;
        tick();
        checkOutput("s4_count",  32'(o_count),  32'h1);
        checkOutput("s4_digits", 32'(o_digits), 32'hAAAA);

        // Scenario 5: auto-scroll over a word with distinct slices
        applyStimulus(128'h0, 128'h0);
        applyStimulus(128'h0000_1111_2222_3333_4444_5555_6666_7777, 128'h0);
        i_window    = 3'd0;
        i_scroll_en = 1'b1;
        tick();
        checkOutput("s5_win_start", 32'(o_window), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            repeat (8) tick();
            checkOutput("s5_win",    32'(o_window), 32'(k % 8));
            checkOutput("s5_digits", 32'(o_digits), 32'(16'h1111 * (k % 8)));
        end
        i_window    = 3'd2;
        i_scroll_en = 1'b0;
        tick();
        checkOutput("s5_manual_win",    32'(o_window), 32'h2);
        checkOutput("s5_manual_digits", 32'(o_digits), 32'h2222);

        // Scenario 6: asynchronous reset between edges while scrolling
        i_scroll_en = 1'b1;
        repeat (13) tick();
        checkOutput("s6_pre_count", 32'(o_count), 32'h3);
        #3;
        i_reset = 1'b1;
        #1;
        checkOutput("s6_digits", 32'(o_digits),        32'h0);
        checkOutput("s6_valid",  32'(o_valid),         32'h0);
        checkOutput("s6_count",  32'(o_count),         32'h0);
        checkOutput("s6_window", 32'(o_window),        32'h0);
        checkOutput("s6_pulse",  32'(o_capture_pulse), 32'h0);
        repeat (2) tick();
        i_reset     = 1'b0;
        i_scroll_en = 1'b0;
        repeat (3) tick();
        checkOutput("s6_post_count", 32'(o_count), 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) i_tag_ready = ~i_tag_ready;
            if (!i_tag_ready) begin
                i_cipher_text = {$urandom, $urandom, $urandom, $urandom};
                i_tag         = {$urandom, $urandom, $urandom, $urandom};
            end
            i_clear   = ($urandom_range(59) == 0);
            i_sel_tag = 1'($urandom);
            if ($urandom_range(3) == 0) i_entry  = 2'($urandom);
            if ($urandom_range(3) == 0) i_window = 3'($urandom);
            if ($urandom_range(39) == 0) i_scroll_en = ~i_scroll_en;
            tick();
        end
        i_clear = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcm_result_viewer.md
# gcm_result_viewer

Captures AES-GCM results (ciphertext and tag) into a small history buffer when the GCM core signals completion, and presents a selectable hex window of any stored result to the seven-segment display driver. It sits between `gcm_aes` and `display` in the board top level, and replaces the level-sensitive "freeze on tag_ready" logic with a clocked, resettable capture path. It adds multi-result history, a manual or auto-scrolling window over the full 128-bit words, and a clear control.

## Interface

Parameters:
- `DATA_W`, 128: width of the ciphertext and tag words. Bit 0 is the MSB, matching `[0:DATA_W-1]` ordering.
- `DIGITS`, 4: hex digits shown per window. The window width is `WIN_W = 4*DIGITS` bits.
- `DEPTH`, 4: number of stored results. Must be a power of 2 and at least 2.
- `SCROLL_DIV`, 50_000_000: clock cycles per auto-scroll step. Must be at least 2.
- Derived: `NWIN = DATA_W/WIN_W`, which must be a power of 2. `WB = $clog2(NWIN)`. `EB = $clog2(DEPTH)`.

Ports:
- `clk` in 1: single clock for all state.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_cipher_text` in `DATA_W`: ciphertext from the GCM core.
- `i_tag` in `DATA_W`: authentication tag from the GCM core.
- `i_tag_ready` in 1: level completion flag from the GCM core.
- `i_clear` in 1: synchronous one-cycle clear of the history.
- `i_sel_tag` in 1: display selector. 0 shows ciphertext, 1 shows tag.
- `i_entry` in `EB`: history entry to show. 0 is the newest entry.
- `i_window` in `WB`: manual window index. 0 is the most significant window.
- `i_scroll_en` in 1: 1 selects auto-scroll, 0 selects `i_window`.
- `o_digits` out `WIN_W`: registered hex window for the display.
- `o_valid` out 1: the selected entry holds a capture.
- `o_count` out `EB+1`: number of stored entries, saturating at `DEPTH`.
- `o_window` out `WB`: window index currently driving `o_digits`.
- `o_capture_pulse` out 1: one-cycle strobe for each capture.

## Operation

- **Edge detect.** `tr_q` registers `i_tag_ready`. Capture fires when `i_tag_ready & ~tr_q`. `tr_q` resets to 0, so a level that is already high after reset captures exactly once. A held-high level never recaptures.
- **History ring.** There are `DEPTH` cipher/tag pairs and a write pointer `wp`.
  - On capture, the pair is written at `wp`, `wp` increments modulo `DEPTH`, and `o_count` increments and saturates at `DEPTH`.
  - When full, a capture overwrites the oldest entry.
  - Entry index `e` maps to slot `(wp - 1 - e) mod DEPTH`.
- **Clear.** `i_clear` sets `wp` and `o_count` to 0. Storage contents are don't-care.
  - If clear and capture occur in the same cycle, the clear is applied first and the capture lands in slot 0, giving `o_count` = 1.
- **Validity.** `o_valid = (i_entry < o_count)`. When it is 0, `o_digits` is forced to 0.
- **Window select.** `o_digits` takes bits `[o_window*WIN_W +: WIN_W]` of the selected word, using MSB-first `[0:DATA_W-1]` indexing.
- **Auto-scroll.**
  - Scroll state machine states: MANUAL (`i_scroll_en` = 0) and SCROLL (`i_scroll_en` = 1).
  - In MANUAL, `o_window` follows `i_window`, registered.
  - On entering SCROLL, the prescaler and the window index both start at 0.
  - In SCROLL, the prescaler counts 0 to `SCROLL_DIV-1`. On terminal count the window increments and wraps from `NWIN-1` to 0.
  - Returning to MANUAL resets the prescaler to 0.
- **Selection changes.** Changes to `i_sel_tag`, `i_entry`, and `i_window` take effect on the output register only. They do not affect the stored data.

## Timing

- **Reset values.** `o_digits` = 0, `o_valid` = 0, `o_count` = 0, `o_window` = 0, `o_capture_pulse` = 0. Internally, `wp`, `tr_q`, and the prescaler reset to 0.
- **Reset mid-operation.** All history is lost and the state machine returns to MANUAL. The next `i_tag_ready` rise is a normal capture.
- **Capture latency.** Let cycle N be the first cycle with `i_tag_ready` sampled high and `tr_q` = 0.
  - The storage write and `o_count` update occur at the end of N.
  - `o_capture_pulse` is high in cycle N+1 only.
  - `o_digits` and `o_valid` reflect the new entry 0 in cycle N+2.
- **Selection latency.** A change on `i_sel_tag`, `i_entry`, or `i_window` (in MANUAL) appears on `o_digits` and `o_window` one cycle later.
- **Scroll step.** `o_window` advances exactly every `SCROLL_DIV` cycles. `o_digits` tracks it in the same cycle, because the output register selects using the next window value.
- **Inputs.** All inputs are synchronous to `clk`. No input requires a handshake.

## Test plan

Parameters for all scenarios: `DATA_W`=128, `DIGITS`=4, `DEPTH`=4, `SCROLL_DIV`=8.

1. **Reset then one capture.**
   - Stimulus: release reset. Drive `i_cipher_text`=0x0123…CDEF repeated and `i_tag`=0xFEDC… repeated, then raise `i_tag_ready` and hold it high for 20 cycles.
   - Required: `o_capture_pulse` high for exactly one cycle, 1 cycle after the rise. `o_count`=1. With `i_window`=0 and `i_sel_tag`=0, `o_digits`=0x0123 two cycles after the rise. With `i_sel_tag`=1, `o_digits`=0xFEDC. No second capture.
2. **Ring wrap.**
   - Stimulus: 6 captures with cipher = 0x…0001 through 0x…0006 in the low window.
   - Required: `o_count`=4. With `i_window`=7, entry 0 shows 0x0006 and entry 3 shows 0x0003.
3. **Invalid entry.**
   - Stimulus: after 2 captures, set `i_entry`=3.
   - Required: `o_valid`=0 and `o_digits`=0x0000. Setting `i_entry`=1 gives `o_valid`=1.
4. **Simultaneous clear and capture.**
   - Stimulus: history full. Pulse `i_clear` in the same cycle that `i_tag_ready` rises.
   - Required: `o_count`=1, and entry 0 holds the new data.
5. **Auto-scroll.**
   - Stimulus: set `i_scroll_en`=1.
   - Required: `o_window` steps 0,1,…,7,0 every 8 cycles, and `o_digits` matches each 16-bit slice. Dropping `i_scroll_en` returns `o_window` to `i_window` after 1 cycle.
6. **Async reset mid-scroll.**
   - Stimulus: assert `i_reset` between clock edges while scrolling with 3 entries stored.
   - Required: all outputs are 0 immediately, before the next edge, and `o_count` stays 0 after release.
